sid_svf_multi: RTL and testbench
================================

SID_SVF_MULTI -- requirements
Module: sid_svf_multi

Parameters
REQ-001 CH, default 2: number of independent filter channels (one per SID), time-multiplexed.
REQ-002 NV, default 3: voices per channel.
REQ-003 DW, default 12: voice and external-input width, unsigned offset-binary.
REQ-004 AW, default 18: signed accumulator and integrator width.
REQ-005 OW, default 16: signed output width per channel.

Interface
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  start-of-sample strobe.
REQ-009 in_ready  out  1  high only in IDLE.
REQ-010 voices  in  CH*NV*DW  voice samples; channel c, voice v at slice (c*NV+v)*DW.
REQ-011 ext_in  in  CH*DW  external input per channel.
REQ-012 fc  in  CH*11  cutoff per channel.
REQ-013 res  in  CH*4  resonance index per channel.
REQ-014 route  in  CH*(NV+1)  per-channel bit k=1: source k (k=NV is ext_in) goes through the filter.
REQ-015 mode  in  CH*4  per channel: [0]=LP, [1]=BP, [2]=HP, [3]=mute unfiltered voice NV-1.
REQ-016 vol  in  CH*4  master volume per channel.
REQ-017 out_valid  out  1  one-cycle pulse when sound has been updated.
REQ-018 sound  out  CH*OW  signed output per channel; channel c at slice c*OW.

Function
REQ-019 When in_valid=1 and in_ready=1, all inputs shall be latched; in_valid while busy shall be ignored.
REQ-020 FSM: IDLE -> MIX (NV+1 cycles, source index k=0..NV) -> INTEG -> HP -> MIXOUT -> VOL; then MIX for the next channel, or DONE after channel CH-1; DONE -> IDLE.
REQ-021 Each source shall be converted to signed as (x - 2^(DW-1)) << 2.
REQ-022 In MIX, the converted source shall be added to Vi if routed; otherwise to Vnf, except voice NV-1 when mode[3]=1, which is dropped. Vi and Vnf clear at MIX entry.
REQ-023 w0 = ((fc+1)*82355) >> 12, truncated to AW bits, unsigned.
REQ-024 q = table[res]: 1448,1328,1218,1117,1024,939,861,790,724,664,609,558,512,470,431,395.
REQ-025 INTEG, using pre-cycle state: Vbp <= Vbp - ((w0*Vhp) >>> 19); Vlp <= Vlp - ((w0*Vbp) >>> 19).
REQ-026 HP: Vhp <= ((q*Vbp) >>> 10) - Vlp - Vi.
REQ-027 MIXOUT: Vf = Vnf - (sum of Vlp, Vbp, Vhp selected by mode[2:0]); Vf = Vnf when mode[2:0]=0.
REQ-028 VOL: sound[c] <= sat_OW((Vf*vol) >>> 5).
REQ-029 Every AW-bit result (Vi, Vnf, Vbp, Vlp, Vhp, Vf) shall saturate to +/-(2^(AW-1)-1) instead of wrapping.
REQ-030 Vbp, Vlp and Vhp state shall be held separately per channel; channels shall not interact.
REQ-031 DONE shall assert out_valid for exactly one cycle. Latency from accept to out_valid = CH*(NV+5)+1 cycles.
REQ-032 Between DONE pulses, sound shall hold its value; channel c's slice updates in its VOL cycle.

Reset
REQ-033 rst shall force IDLE, in_ready=1, out_valid=0, sound=0, and all Vbp/Vlp/Vhp/Vi/Vnf/Vf=0.
REQ-034 rst asserted mid-sample shall abort that sample with no out_valid; the first in_valid after rst releases starts a fresh sample.

Verification
REQ-035 Reset release -> in_ready=1, out_valid=0, sound=0 on all channels.
REQ-036 All voices and ext_in = 2048, route=0, vol=15 -> out_valid after CH*(NV+5)+1 cycles, sound=0.
REQ-037 Ch0: voice0=4095, others 2048, route=0, vol=15 -> sound[0]=3838; ch1 stays 0.
REQ-038 Ch1: all sources 4095, route=0, vol=15, mode[3]=0 -> Vnf=32752, sound[1]=15352; ch0 unaffected.
REQ-039 in_valid pulsed every cycle for 3*latency cycles -> exactly 3 out_valid pulses, one per accepted sample.
REQ-040 Ch0: route=all, fc=2047, res=0, mode=LP, step input held for 200 samples -> integrators never wrap, sound monotonic sign, |sound| <= 32767.

Source files
------------

// File: rtl/sid_svf_multi.sv
// sid_svf_multi
// Time-multiplexed SID-style state-variable filter shared by CH channels.
// One sample is processed per in_valid handshake. For each channel, the
// sequencer mixes the NV voices plus the external input into the filter
// input (Vi) and the bypass sum (Vnf). It then advances that channel's
// integrators, forms the high-pass node, mixes the selected filter outputs
// and applies the master volume.
// Every AW-bit node saturates symmetrically instead of wrapping.
module sid_svf_multi #(
    parameter int CH = 2,
    parameter int NV = 3,
    parameter int DW = 12,
    parameter int AW = 18,
    parameter int OW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*NV*DW-1:0]   voices,
    input  logic [CH*DW-1:0]      ext_in,
    input  logic [CH*11-1:0]      fc,
    input  logic [CH*4-1:0]       res,
    input  logic [CH*(NV+1)-1:0]  route,
    input  logic [CH*4-1:0]       mode,
    input  logic [CH*4-1:0]       vol,
    output logic                  out_valid,
    output logic [CH*OW-1:0]      sound
);

    localparam int KW  = (NV + 1 > 1) ? $clog2(NV + 1) : 1;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    // Working width for products; large enough that no intermediate wraps.
    localparam int PW  = 2 * AW + 4;

    localparam logic signed [PW-1:0] ONE     = {{(PW-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0] ZERO    = {PW{1'b0}};
    localparam logic signed [PW-1:0] AMAX    = (ONE <<< (AW - 1)) - ONE;
    localparam logic signed [PW-1:0] AMIN    = -AMAX;
    localparam logic signed [PW-1:0] OMAX    = (ONE <<< (OW - 1)) - ONE;
    localparam logic signed [PW-1:0] OMIN    = -OMAX;
    localparam logic signed [PW-1:0] HALF    = ONE <<< (DW - 1);
    localparam logic signed [PW-1:0] AW_MASK = (ONE <<< AW) - ONE;
    localparam logic signed [PW-1:0] W0K     = PW'(32'sd82355);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MIX    = 3'd1,
        S_INTEG  = 3'd2,
        S_HP     = 3'd3,
        S_MIXOUT = 3'd4,
        S_VOL    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Clamp a wide value into the symmetric AW-bit range.
    function automatic logic signed [AW-1:0] sat_aw(input logic signed [PW-1:0] x);
        logic signed [AW-1:0] r;
        if (x > AMAX) begin
            r = AMAX[AW-1:0];
        end else if (x < AMIN) begin
            r = AMIN[AW-1:0];
        end else begin
            r = x[AW-1:0];
        end
        return r;
    endfunction

    // Clamp a wide value into the symmetric OW-bit output range.
    function automatic logic signed [OW-1:0] sat_ow(input logic signed [PW-1:0] x);
        logic signed [OW-1:0] r;
        if (x > OMAX) begin
            r = OMAX[OW-1:0];
        end else if (x < OMIN) begin
            r = OMIN[OW-1:0];
        end else begin
            r = x[OW-1:0];
        end
        return r;
    endfunction

    // Sign-extend an AW-bit node to the working width.
    function automatic logic signed [PW-1:0] sx(input logic signed [AW-1:0] v);
        return {{(PW-AW){v[AW-1]}}, v};
    endfunction

    // Resonance index to 1/Q in Q10 fixed point.
    function automatic logic [10:0] q_lut(input logic [3:0] idx);
        logic [10:0] q;
        case (idx)
            4'd0:    q = 11'd1448;
            4'd1:    q = 11'd1328;
            4'd2:    q = 11'd1218;
            4'd3:    q = 11'd1117;
            4'd4:    q = 11'd1024;
            4'd5:    q = 11'd939;
            4'd6:    q = 11'd861;
            4'd7:    q = 11'd790;
            4'd8:    q = 11'd724;
            4'd9:    q = 11'd664;
            4'd10:   q = 11'd609;
            4'd11:   q = 11'd558;
            4'd12:   q = 11'd512;
            4'd13:   q = 11'd470;
            4'd14:   q = 11'd431;
            4'd15:   q = 11'd395;
            default: q = 11'd1024;
        endcase
        return q;
    endfunction

    state_t state_r;
    state_t next_s;
    logic   in_ready_r;
    logic   out_valid_r;

    logic [KW-1:0]  k_r;
    logic [CHW-1:0] ch_r;

    logic [CH*NV*DW-1:0]  voices_r;
    logic [CH*DW-1:0]     ext_r;
    logic [CH*11-1:0]     fc_r;
    logic [CH*4-1:0]      res_r;
    logic [CH*(NV+1)-1:0] route_r;
    logic [CH*4-1:0]      mode_r;
    logic [CH*4-1:0]      vol_r;

    logic signed [AW-1:0] vi_r;
    logic signed [AW-1:0] vnf_r;
    logic signed [AW-1:0] vf_r;
    logic signed [AW-1:0] vbp_r [CH];
    logic signed [AW-1:0] vlp_r [CH];
    logic signed [AW-1:0] vhp_r [CH];
    logic [CH*OW-1:0]     sound_r;

    logic [KW-1:0]        vk_s;
    int                   voice_idx_s;
    logic [DW-1:0]        src_raw_s;
    logic signed [PW-1:0] conv_s;
    logic                 routed_s;
    logic                 drop_s;
    logic signed [PW-1:0] vi_base_s;
    logic signed [PW-1:0] vnf_base_s;
    logic signed [AW-1:0] vi_mix_next_s;
    logic signed [AW-1:0] vnf_mix_next_s;
    logic [10:0]          fc_s;
    logic signed [PW-1:0] w0_full_s;
    logic signed [PW-1:0] w0_s;
    logic signed [PW-1:0] cur_bp_s;
    logic signed [PW-1:0] cur_lp_s;
    logic signed [PW-1:0] cur_hp_s;
    logic signed [AW-1:0] integ_bp_s;
    logic signed [AW-1:0] integ_lp_s;
    logic signed [PW-1:0] q_s;
    logic signed [AW-1:0] hp_next_s;
    logic [3:0]           mode_s;
    logic signed [PW-1:0] sum_s;
    logic signed [AW-1:0] vf_next_s;
    logic signed [PW-1:0] vol_prod_s;
    logic signed [OW-1:0] snd_next_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sound     = sound_r;

    // State register plus the registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_s;
            in_ready_r  <= (next_s == S_IDLE);
            out_valid_r <= (state_r == S_DONE);
        end
    end

    // Next-state sequencing through the per-channel step list.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) next_s = S_MIX;
                else          next_s = S_IDLE;
            end
            S_MIX: begin
                if (k_r == KW'(NV)) next_s = S_INTEG;
                else                next_s = S_MIX;
            end
            S_INTEG:  next_s = S_HP;
            S_HP:     next_s = S_MIXOUT;
            S_MIXOUT: next_s = S_VOL;
            S_VOL: begin
                if (ch_r == CHW'(CH - 1)) next_s = S_DONE;
                else                      next_s = S_MIX;
            end
            S_DONE:   next_s = S_IDLE;
            default:  next_s = S_IDLE;
        endcase
    end

    // Arithmetic for the currently selected channel and source.
    always_comb begin
        // Source selection: index NV is the external input.
        if (k_r == KW'(NV)) vk_s = {KW{1'b0}};
        else                vk_s = k_r;
        voice_idx_s = (int'(ch_r) * NV + int'(vk_s)) * DW;
        if (k_r == KW'(NV)) src_raw_s = ext_r[int'(ch_r) * DW +: DW];
        else                src_raw_s = voices_r[voice_idx_s +: DW];
        conv_s = ($signed({{(PW-DW){1'b0}}, src_raw_s}) - HALF) <<< 2;

        mode_s   = mode_r[int'(ch_r) * 4 +: 4];
        routed_s = route_r[int'(ch_r) * (NV + 1) + int'(k_r)];
        drop_s   = (k_r == KW'(NV - 1)) && mode_s[3];

        // The first source of a channel starts both sums from zero.
        if (k_r == {KW{1'b0}}) begin
            vi_base_s  = ZERO;
            vnf_base_s = ZERO;
        end else begin
            vi_base_s  = sx(vi_r);
            vnf_base_s = sx(vnf_r);
        end
        if (routed_s) vi_mix_next_s = sat_aw(vi_base_s + conv_s);
        else          vi_mix_next_s = sat_aw(vi_base_s);
        if (!routed_s && !drop_s) vnf_mix_next_s = sat_aw(vnf_base_s + conv_s);
        else                      vnf_mix_next_s = sat_aw(vnf_base_s);

        // Cutoff coefficient, truncated to AW unsigned bits.
        fc_s      = fc_r[int'(ch_r) * 11 +: 11];
        w0_full_s = (($signed({{(PW-11){1'b0}}, fc_s}) + ONE) * W0K) >>> 12;
        w0_s      = w0_full_s & AW_MASK;

        cur_bp_s = sx(vbp_r[ch_r]);
        cur_lp_s = sx(vlp_r[ch_r]);
        cur_hp_s = sx(vhp_r[ch_r]);

        // Both integrators read the pre-update state.
        integ_bp_s = sat_aw(cur_bp_s - ((w0_s * cur_hp_s) >>> 19));
        integ_lp_s = sat_aw(cur_lp_s - ((w0_s * cur_bp_s) >>> 19));

        q_s       = $signed({{(PW-11){1'b0}}, q_lut(res_r[int'(ch_r) * 4 +: 4])});
        hp_next_s = sat_aw(((q_s * cur_bp_s) >>> 10) - cur_lp_s - sx(vi_r));

        // Selected filter outputs are subtracted from the bypass sum.
        sum_s = ZERO;
        if (mode_s[0]) sum_s = sum_s + cur_lp_s;
        else           sum_s = sum_s;
        if (mode_s[1]) sum_s = sum_s + cur_bp_s;
        else           sum_s = sum_s;
        if (mode_s[2]) sum_s = sum_s + cur_hp_s;
        else           sum_s = sum_s;
        vf_next_s = sat_aw(sx(vnf_r) - sum_s);

        vol_prod_s = (sx(vf_r) * $signed({{(PW-4){1'b0}}, vol_r[int'(ch_r) * 4 +: 4]})) >>> 5;
        snd_next_s = sat_ow(vol_prod_s);
    end

    // Input capture, step counters and filter/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r      <= {KW{1'b0}};
            ch_r     <= {CHW{1'b0}};
            voices_r <= {(CH*NV*DW){1'b0}};
            ext_r    <= {(CH*DW){1'b0}};
            fc_r     <= {(CH*11){1'b0}};
            res_r    <= {(CH*4){1'b0}};
            route_r  <= {(CH*(NV+1)){1'b0}};
            mode_r   <= {(CH*4){1'b0}};
            vol_r    <= {(CH*4){1'b0}};
            vi_r     <= {AW{1'b0}};
            vnf_r    <= {AW{1'b0}};
            vf_r     <= {AW{1'b0}};
            sound_r  <= {(CH*OW){1'b0}};
            for (int c = 0; c < CH; c++) begin
                vbp_r[c] <= {AW{1'b0}};
                vlp_r[c] <= {AW{1'b0}};
                vhp_r[c] <= {AW{1'b0}};
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        voices_r <= voices;
                        ext_r    <= ext_in;
                        fc_r     <= fc;
                        res_r    <= res;
                        route_r  <= route;
                        mode_r   <= mode;
                        vol_r    <= vol;
                        k_r      <= {KW{1'b0}};
                        ch_r     <= {CHW{1'b0}};
                    end
                end
                S_MIX: begin
                    vi_r  <= vi_mix_next_s;
                    vnf_r <= vnf_mix_next_s;
                    if (k_r == KW'(NV)) k_r <= {KW{1'b0}};
                    else                k_r <= k_r + KW'(1);
                end
                S_INTEG: begin
                    vbp_r[ch_r] <= integ_bp_s;
                    vlp_r[ch_r] <= integ_lp_s;
                end
                S_HP: begin
                    vhp_r[ch_r] <= hp_next_s;
                end
                S_MIXOUT: begin
                    vf_r <= vf_next_s;
                end
                S_VOL: begin
                    sound_r[int'(ch_r) * OW +: OW] <= snd_next_s;
                    k_r <= {KW{1'b0}};
                    if (ch_r == CHW'(CH - 1)) ch_r <= {CHW{1'b0}};
                    else                      ch_r <= ch_r + CHW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sid_svf_multi.sv
// Self-checking bench for sid_svf_multi. A sample-level reference model
// (plain integer arithmetic per channel) predicts every output.
module tb_sid_svf_multi;

    localparam int CH  = 2;
    localparam int NV  = 3;
    localparam int DW  = 12;
    localparam int AW  = 18;
    localparam int OW  = 16;
    localparam int LAT = CH * (NV + 5) + 1;
    localparam longint AMAX = 131071;
    localparam longint OMAX = 32767;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*NV*DW-1:0]  voices;
    logic [CH*DW-1:0]     ext_in;
    logic [CH*11-1:0]     fc;
    logic [CH*4-1:0]      res;
    logic [CH*(NV+1)-1:0] route;
    logic [CH*4-1:0]      mode;
    logic [CH*4-1:0]      vol;
    logic                 out_valid;
    logic [CH*OW-1:0]     sound;

    sid_svf_multi #(.CH(CH), .NV(NV), .DW(DW), .AW(AW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .voices(voices), .ext_in(ext_in), .fc(fc), .res(res), .route(route),
        .mode(mode), .vol(vol), .out_valid(out_valid), .sound(sound)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;
    int src    [CH][NV+1];
    int fcv    [CH];
    int resv   [CH];
    int routev [CH];
    int modev  [CH];
    int volv   [CH];
    longint m_bp [CH];
    longint m_lp [CH];
    longint m_hp [CH];
    longint exp_snd [CH];
    longint q_tab [16] = '{1448, 1328, 1218, 1117, 1024, 939, 861, 790,
                           724, 664, 609, 558, 512, 470, 431, 395};
    longint exq [$];
    int acc;
    int pulses;
    int n;

    function automatic longint sat(input longint x, input longint m);
        if (x > m) return m;
        if (x < -m) return -m;
        return x;
    endfunction

    function automatic longint snd_of(input int c);
        logic signed [OW-1:0] s;
        s = sound[c*OW +: OW];
        return longint'(s);
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int c = 0; c < CH; c++) begin
            for (int v = 0; v < NV; v++) voices[(c*NV+v)*DW +: DW] = DW'(src[c][v]);
            ext_in[c*DW +: DW]       = DW'(src[c][NV]);
            fc[c*11 +: 11]           = 11'(fcv[c]);
            res[c*4 +: 4]            = 4'(resv[c]);
            route[c*(NV+1) +: NV+1]  = (NV+1)'(routev[c]);
            mode[c*4 +: 4]           = 4'(modev[c]);
            vol[c*4 +: 4]            = 4'(volv[c]);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_bp[c] = 0; m_lp[c] = 0; m_hp[c] = 0; exp_snd[c] = 0;
        end
    endtask

    // One whole sample for every channel, straight from the filter equations.
    task automatic model_sample();
        longint vi, vnf, x, w0, q, nbp, nlp, sum, vf;
        for (int c = 0; c < CH; c++) begin
            vi = 0;
            vnf = 0;
            for (int k = 0; k <= NV; k++) begin
                x = (longint'(src[c][k]) - 2048) * 4;
                if (((routev[c] >> k) & 1) != 0) vi = sat(vi + x, AMAX);
                else if (!(k == NV - 1 && ((modev[c] >> 3) & 1) != 0)) vnf = sat(vnf + x, AMAX);
            end
            w0 = (((longint'(fcv[c]) + 1) * 82355) / 4096) % (longint'(1) << AW);
            q  = q_tab[resv[c]];
            nbp = sat(m_bp[c] - ((w0 * m_hp[c]) >>> 19), AMAX);
            nlp = sat(m_lp[c] - ((w0 * m_bp[c]) >>> 19), AMAX);
            m_bp[c] = nbp;
            m_lp[c] = nlp;
            m_hp[c] = sat(((q * m_bp[c]) >>> 10) - m_lp[c] - vi, AMAX);
            sum = 0;
            if ((modev[c] & 1) != 0) sum += m_lp[c];
            if ((modev[c] & 2) != 0) sum += m_bp[c];
            if ((modev[c] & 4) != 0) sum += m_hp[c];
            vf = sat(vnf - sum, AMAX);
            exp_snd[c] = sat((vf * volv[c]) >>> 5, OMAX);
        end
    endtask

    task automatic set_all(input int c, input int val);
        for (int k = 0; k <= NV; k++) src[c][k] = val;
    endtask

    // Launch one sample, time its latency and compare the outputs.
    task automatic run_sample(input string tag);
        pack();
        check({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        model_sample();
        check({tag, "_busy"}, in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_latency"}, n, LAT);
        for (int c = 0; c < CH; c++) check($sformatf("%s_snd%0d", tag, c), snd_of(c), exp_snd[c]);
        @(negedge clk);
        check({tag, "_pulse_end"}, out_valid, 0);
        check({tag, "_hold0"}, snd_of(0), exp_snd[0]);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < CH; c++) begin
            set_all(c, 2048);
            fcv[c] = 0; resv[c] = 0; routev[c] = 0; modev[c] = 0; volv[c] = 15;
        end
        pack();
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        for (int c = 0; c < CH; c++) check($sformatf("rst_snd%0d", c), snd_of(c), 0);

        // Silence: midscale everywhere.
        run_sample("silence");

        // Channel 0 voice 0 at full scale, bypassed.
        src[0][0] = 4095;
        run_sample("ch0_v0");
        check("ch0_v0_const", snd_of(0), 3838);
        check("ch0_v0_ch1_zero", snd_of(1), 0);

        // Channel 1 every source at full scale, bypassed.
        set_all(0, 2048);
        set_all(1, 4095);
        run_sample("ch1_full");
        check("ch1_full_const", snd_of(1), 15352);
        check("ch1_full_ch0_zero", snd_of(0), 0);

        // Voice NV-1 muted by mode[3].
        modev[1] = 8;
        run_sample("ch1_mute");
        check("ch1_mute_const", snd_of(1), 11514);

        // Randomised samples across every control field.
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k <= NV; k++) src[c][k] = $urandom_range(4095, 0);
                fcv[c]    = $urandom_range(2047, 0);
                resv[c]   = $urandom_range(15, 0);
                routev[c] = $urandom_range(15, 0);
                modev[c]  = $urandom_range(15, 0);
                volv[c]   = $urandom_range(15, 0);
            end
            run_sample($sformatf("rand%0d", i));
        end

        // in_valid held high: only idle-time strobes are accepted.
        pack();
        acc = 0;
        pulses = 0;
        for (int i = 0; i < 5 * LAT; i++) begin
            in_valid = (i < 3 * LAT);
            if (out_valid === 1'b1) begin
                pulses++;
                if (exq.size() >= CH) begin
                    for (int c = 0; c < CH; c++) check($sformatf("burst_snd%0d", c), snd_of(c), exq.pop_front());
                end else begin
                    check("burst_queue", exq.size(), CH);
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                acc++;
                model_sample();
                for (int c = 0; c < CH; c++) exq.push_back(exp_snd[c]);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("burst_accepts", acc, 3);
        check("burst_pulses", pulses, acc);
        check("burst_drained", exq.size(), 0);

        // Reset in the middle of a sample aborts it.
        for (int c = 0; c < CH; c++) begin
            set_all(c, 4095);
            routev[c] = 15; modev[c] = 1; fcv[c] = 1000; resv[c] = 5; volv[c] = 15;
        end
        pack();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_ready", in_ready, 1);
        for (int c = 0; c < CH; c++) check($sformatf("abort_snd%0d", c), snd_of(c), 0);
        for (int i = 0; i < 4; i++) run_sample($sformatf("fresh%0d", i));

        // Low-pass step response at maximum cutoff for 200 samples.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        set_all(0, 4095);
        routev[0] = 15; fcv[0] = 2047; resv[0] = 0; modev[0] = 1; volv[0] = 15;
        set_all(1, 2048);
        routev[1] = 0; fcv[1] = 0; resv[1] = 0; modev[1] = 0; volv[1] = 15;
        for (int i = 0; i < 200; i++) begin
            run_sample($sformatf("step%0d", i));
            check($sformatf("step%0d_sign", i), (snd_of(0) >= 0) ? 1 : 0, 1);
            check($sformatf("step%0d_mag", i), (snd_of(0) <= OMAX && snd_of(0) >= -OMAX) ? 1 : 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
